// File: rtl/mfm_data_separator.sv
// rtl/mfm_data_separator.sv - digital PLL and data separator for raw MFM read data
// Tracks edges with a proportionally corrected half-cell phase counter and splits clock/data bits.
module mfm_data_separator #(
  parameter int HALF_CELL   = 10,
  parameter int CNT_W       = 5,
  parameter int SYNC_STAGES = 2,
  parameter int GAIN_SHIFT  = 0,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_COUNT  = 16,
  parameter int MAX_IDLE    = 8
) (
  input  logic                    clk_50,
  input  logic                    rst_n,
  input  logic                    raw_mfm,
  input  logic                    slip,
  output logic                    dpll_clk,
  output logic                    window,
  output logic                    bit_valid,
  output logic                    bit_data,
  output logic                    clock_bit,
  output logic signed [CNT_W:0]   phase_err,
  output logic                    err_valid,
  output logic                    locked
);

  localparam int LC_W   = $clog2(LOCK_COUNT + 1);
  localparam int IDLE_W = $clog2(MAX_IDLE + 1);
  localparam logic [CNT_W-1:0]  CENTER   = CNT_W'(HALF_CELL / 2);
  localparam logic [CNT_W:0]    LAST_EXT = (CNT_W + 1)'(HALF_CELL - 1);
  localparam logic [CNT_W:0]    IN_TOL   = (CNT_W + 1)'(LOCK_TOL);
  localparam logic [LC_W-1:0]   LOCK_MAX = LC_W'(LOCK_COUNT);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(MAX_IDLE);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic [CNT_W-1:0]       ph_q, ph_d;
  logic                   window_q, window_d;
  logic                   dpll_q, dpll_d;
  logic                   hit_q, hit_d;
  logic                   clk_hold_q, clk_hold_d;
  logic                   bit_valid_q, bit_valid_d;
  logic                   bit_data_q, bit_data_d;
  logic                   clock_bit_q, clock_bit_d;
  logic signed [CNT_W:0]  phase_err_q, phase_err_d;
  logic                   err_valid_q, err_valid_d;
  logic [LC_W-1:0]        lock_cnt_q, lock_cnt_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic                   locked_q, locked_d;

  logic                   mfm_edge;
  logic signed [CNT_W:0]  err, err_shift, c_ext;
  logic [CNT_W:0]         err_abs;
  logic                   close, win_hit;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], raw_mfm};
    dly_d       = sync_q[SYNC_STAGES-1];
    mfm_edge    = sync_q[SYNC_STAGES-1] & ~dly_q;

    // Corrected phase c stays between ph and CENTER, so it never leaves the counter range
    err       = $signed({1'b0, ph_q}) - $signed({1'b0, CENTER});
    err_shift = err >>> GAIN_SHIFT;
    c_ext     = mfm_edge ? ($signed({1'b0, ph_q}) - err_shift) : $signed({1'b0, ph_q});
    err_abs   = err[CNT_W] ? $unsigned(-err) : $unsigned(err);
    close     = ($unsigned(c_ext) == LAST_EXT);
    win_hit   = hit_q | mfm_edge;

    ph_d        = close ? '0 : (c_ext[CNT_W-1:0] + CNT_W'(1));
    window_d    = window_q ^ close ^ slip;
    dpll_d      = dpll_q ^ close;
    hit_d       = close ? 1'b0 : win_hit;
    clk_hold_d  = (close & ~window_q) ? win_hit : clk_hold_q;
    bit_valid_d = close & window_q;
    bit_data_d  = (close & window_q) ? win_hit : bit_data_q;
    clock_bit_d = (close & window_q) ? clk_hold_q : clock_bit_q;
    phase_err_d = mfm_edge ? err : phase_err_q;
    err_valid_d = mfm_edge;

    lock_cnt_d  = lock_cnt_q;
    idle_d      = idle_q;
    locked_d    = locked_q;
    if (mfm_edge) begin
      idle_d = '0;
      if (err_abs <= IN_TOL) begin
        lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : (lock_cnt_q + LC_W'(1));
        locked_d   = locked_q | (lock_cnt_d == LOCK_MAX);
      end else begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end
    end else if (close && !hit_q) begin
      idle_d = (idle_q == IDLE_MAX) ? idle_q : (idle_q + IDLE_W'(1));
      if (idle_d == IDLE_MAX) begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      sync_q      <= '0;
      dly_q       <= 1'b0;
      ph_q        <= '0;
      window_q    <= 1'b0;
      dpll_q      <= 1'b1;
      hit_q       <= 1'b0;
      clk_hold_q  <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_data_q  <= 1'b0;
      clock_bit_q <= 1'b0;
      phase_err_q <= '0;
      err_valid_q <= 1'b0;
      lock_cnt_q  <= '0;
      idle_q      <= '0;
      locked_q    <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      dly_q       <= dly_d;
      ph_q        <= ph_d;
      window_q    <= window_d;
      dpll_q      <= dpll_d;
      hit_q       <= hit_d;
      clk_hold_q  <= clk_hold_d;
      bit_valid_q <= bit_valid_d;
      bit_data_q  <= bit_data_d;
      clock_bit_q <= clock_bit_d;
      phase_err_q <= phase_err_d;
      err_valid_q <= err_valid_d;
      lock_cnt_q  <= lock_cnt_d;
      idle_q      <= idle_d;
      locked_q    <= locked_d;
    end
  end

  assign dpll_clk  = dpll_q;
  assign window    = window_q;
  assign bit_valid = bit_valid_q;
  assign bit_data  = bit_data_q;
  assign clock_bit = clock_bit_q;
  assign phase_err = phase_err_q;
  assign err_valid = err_valid_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_mfm_data_separator.sv
// tb/tb_mfm_data_separator.sv - scoreboard bench for mfm_data_separator
// A second instance with GAIN_SHIFT=1 shares the inputs for the half-gain correction case.
module tb_mfm_data_separator;

  logic clk_50 = 1'b0;
  logic rst_n, raw_mfm, slip;
  logic dpll_clk, window, bit_valid, bit_data, clock_bit, err_valid, locked;
  logic signed [5:0] phase_err;
  logic dpll_clk1, window1, bit_valid1, bit_data1, clock_bit1, err_valid1, locked1;
  logic signed [5:0] phase_err1;

  always #5 clk_50 = ~clk_50;

  mfm_data_separator #(.GAIN_SHIFT(0)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .raw_mfm(raw_mfm), .slip(slip),
    .dpll_clk(dpll_clk), .window(window), .bit_valid(bit_valid), .bit_data(bit_data),
    .clock_bit(clock_bit), .phase_err(phase_err), .err_valid(err_valid), .locked(locked)
  );

  mfm_data_separator #(.GAIN_SHIFT(1)) dut_half (
    .clk_50(clk_50), .rst_n(rst_n), .raw_mfm(raw_mfm), .slip(slip),
    .dpll_clk(dpll_clk1), .window(window1), .bit_valid(bit_valid1), .bit_data(bit_data1),
    .clock_bit(clock_bit1), .phase_err(phase_err1), .err_valid(err_valid1), .locked(locked1)
  );

  int checks = 0;
  int errors = 0;
  logic signed [5:0] err_q[$];
  logic [1:0]        bit_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a phase error or a bit pair
  always @(negedge clk_50) begin
    if (err_valid) begin
      if (err_q.size() == 0) chk("unexpected_err_valid", int'(phase_err), 99);
      else                   chk("phase_err", int'(phase_err), int'(err_q.pop_front()));
    end
    if (bit_valid) begin
      if (bit_q.size() == 0) chk("unexpected_bit_valid", int'({bit_data, clock_bit}), 99);
      else                   chk("bits_data_clock", int'({bit_data, clock_bit}), int'(bit_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    slip  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      raw_mfm = ~raw_mfm;
      tick();
    end
    raw_mfm = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic wait_close(output int n);
    logic prev;
    prev = dpll_clk;
    n = 0;
    do begin
      tick();
      n++;
    end while (dpll_clk == prev && n < 60);
    if (dpll_clk == prev) chk("close_timeout", n, -1);
  endtask

  task automatic wait_data_start();
    int n;
    for (int t = 0; t < 3; t++) begin
      wait_close(n);
      if (window) return;
    end
    chk("data_window_timeout", int'(window), 1);
  endtask

  // Edge becomes visible to the phase logic while ph == p (p >= 2) after a window start
  task automatic place_edge(input int p);
    repeat (p - 2) tick();
    raw_mfm = 1'b1;
    tick();
    tick();
    raw_mfm = 1'b0;
  endtask

  task automatic wait_err();
    int n;
    n = 0;
    while (!err_valid && n < 20) begin
      tick();
      n++;
    end
    if (!err_valid) chk("err_timeout", 0, 1);
  endtask

  task automatic lock_run(input string name);
    for (int k = 1; k <= 16; k++) begin
      wait_data_start();
      err_q.push_back(6'sd0);
      bit_q.push_back(2'b10);
      place_edge(5);
      wait_err();
      chk(name, int'(locked), int'(k == 16));
    end
  endtask

  initial begin
    int n, n0, n1;
    logic p0, p1;
    rst_n = 1'b0; raw_mfm = 1'b0; slip = 1'b0;

    // Reset values and free run
    do_reset();
    chk("rst_dpll_clk",  int'(dpll_clk), 1);
    chk("rst_window",    int'(window), 0);
    chk("rst_bit_valid", int'(bit_valid), 0);
    chk("rst_bit_data",  int'(bit_data), 0);
    chk("rst_clock_bit", int'(clock_bit), 0);
    chk("rst_phase_err", int'(phase_err), 0);
    chk("rst_err_valid", int'(err_valid), 0);
    chk("rst_locked",    int'(locked), 0);
    repeat (3) bit_q.push_back(2'b00);
    wait_close(n);
    chk("first_close", n, 10);
    for (int i = 0; i < 5; i++) begin
      wait_close(n);
      chk("close_period", n, 10);
      chk("bit_valid_at_close", int'(bit_valid), int'(i % 2 == 0));
    end
    chk("freerun_locked", int'(locked), 0);

    // Ideal stream to lock, idle drop, relock, then a large error
    do_reset();
    lock_run("lock_ramp");
    repeat (4) bit_q.push_back(2'b00);
    wait_close(n);
    for (int i = 1; i <= 8; i++) begin
      wait_close(n);
      chk("idle_locked", int'(locked), int'(i < 8));
    end
    lock_run("relock_ramp");
    wait_data_start();
    err_q.push_back(6'sd4);
    bit_q.push_back(2'b10);
    place_edge(9);
    wait_err();
    chk("big_err_unlock", int'(locked), 0);
    wait_close(n);

    // Correction at ph = 8: full snap vs half gain
    do_reset();
    wait_data_start();
    err_q.push_back(6'sd3);
    bit_q.push_back(2'b10);
    place_edge(8);
    wait_err();
    chk("half_gain_err_valid", int'(err_valid1), 1);
    chk("half_gain_phase_err", int'(phase_err1), 3);
    p0 = dpll_clk; p1 = dpll_clk1; n0 = 0; n1 = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (n0 == 0 && dpll_clk != p0) n0 = i;
      if (n1 == 0 && dpll_clk1 != p1) n1 = i;
    end
    chk("snap_close_delay", n0, 4);
    chk("half_close_delay", n1, 2);

    // Slip mid-window, then slip coinciding with a close
    do_reset();
    repeat (4) tick();
    slip = 1'b1;
    tick();
    slip = 1'b0;
    chk("slip_window", int'(window), 1);
    chk("slip_dpll_clk", int'(dpll_clk), 1);
    bit_q.push_back(2'b00);
    repeat (5) tick();
    chk("slip_early_bit_valid", int'(bit_valid), 1);
    chk("slip_close_dpll", int'(dpll_clk), 0);
    chk("slip_close_window", int'(window), 0);
    repeat (9) tick();
    slip = 1'b1;
    tick();
    slip = 1'b0;
    chk("slip_on_close_window", int'(window), 0);
    chk("slip_on_close_dpll", int'(dpll_clk), 1);
    repeat (15) tick();

    chk("err_queue_empty", err_q.size(), 0);
    chk("bit_queue_empty", bit_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
